// File: rtl/pipe_in_stream_fifo.sv
// Input-pipe stream FIFO: absorbs endpoint writes that cannot be stalled and
// re-presents them as a show-ahead valid/ready stream. Words arriving while
// the FIFO is full are dropped and counted.
//
// Structure: a DEPTH x 32 array with a registered read port feeds a single
// output register (dout/dout_valid). The output register is reloaded on the
// same edge that pops it, so back-to-back pops drain one word per cycle.
// rd_ptr addresses the next word still waiting in the array; the word sitting
// in the output register has already left the array, so its slot is free.
// A new word spends one cycle in the array before it can reach dout.
module pipe_in_stream_fifo #(
  parameter int DEPTH        = 16,
  parameter int ADDR_W       = 4,
  parameter int AFULL_THRESH = DEPTH - 4,
  parameter int DROP_CNT_W   = 16
) (
  input  logic                  ti_clk,
  input  logic                  ti_reset,
  input  logic                  ep_write,
  input  logic [31:0]           ep_dataout,
  output logic [31:0]           dout,
  output logic                  dout_valid,
  input  logic                  dout_ready,
  output logic [ADDR_W:0]       count,
  output logic                  almost_full,
  output logic                  overflow,
  output logic [DROP_CNT_W-1:0] drop_count,
  input  logic                  clear_overflow
);

  localparam logic [ADDR_W:0]       FULL_CNT  = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]       AFULL_CNT = (ADDR_W+1)'(AFULL_THRESH);
  localparam logic [DROP_CNT_W-1:0] DROP_MAX  = '1;

  logic [31:0]           r_mem [DEPTH];
  logic [ADDR_W-1:0]     r_wr_ptr;
  logic [ADDR_W-1:0]     r_rd_ptr;
  logic [ADDR_W:0]       r_count;
  logic [31:0]           r_dout;
  logic                  r_dout_valid;
  logic                  r_almost_full;
  logic                  r_overflow;
  logic [DROP_CNT_W-1:0] r_drop_count;

  logic                  w_full;
  logic                  w_pop;
  logic                  w_push;
  logic                  w_drop;
  logic                  w_load;
  logic [ADDR_W:0]       w_mem_cnt;
  logic [ADDR_W:0]       w_count_next;

  // Handshake decode: a pop frees a slot, so a full FIFO still accepts a push
  // in the same cycle; only an unpopped full FIFO drops the incoming word.
  always_comb begin
    w_full       = (r_count == FULL_CNT);
    w_pop        = r_dout_valid & dout_ready;
    w_push       = ep_write & (~w_full | w_pop);
    w_drop       = ep_write & w_full & ~w_pop;
    w_mem_cnt    = r_count - {{ADDR_W{1'b0}}, r_dout_valid};
    w_load       = (w_mem_cnt != '0) & (~r_dout_valid | w_pop);
    w_count_next = r_count + {{ADDR_W{1'b0}}, w_push} - {{ADDR_W{1'b0}}, w_pop};
  end

  // Storage array write port (no reset, maps onto block RAM).
  always_ff @(posedge ti_clk) begin
    if (w_push && !ti_reset) begin
      r_mem[r_wr_ptr] <= ep_dataout;
    end
  end

  // Pointers, occupancy and almost_full (taken from next-state count).
  always_ff @(posedge ti_clk) begin
    if (ti_reset) begin
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_count       <= '0;
      r_almost_full <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_load) r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count       <= w_count_next;
      r_almost_full <= (w_count_next >= AFULL_CNT);
    end
  end

  // Show-ahead output register: reload from the array when empty or popped,
  // otherwise hold so dout stays stable while the consumer stalls.
  always_ff @(posedge ti_clk) begin
    if (ti_reset) begin
      r_dout       <= '0;
      r_dout_valid <= 1'b0;
    end else if (w_load) begin
      r_dout       <= r_mem[r_rd_ptr];
      r_dout_valid <= 1'b1;
    end else if (w_pop) begin
      r_dout       <= '0;
      r_dout_valid <= 1'b0;
    end
  end

  // Drop bookkeeping: a drop in the same cycle as a clear wins and restarts
  // the count at one; the counter saturates instead of wrapping.
  always_ff @(posedge ti_clk) begin
    if (ti_reset) begin
      r_overflow   <= 1'b0;
      r_drop_count <= '0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
      if (clear_overflow) begin
        r_drop_count <= {{(DROP_CNT_W-1){1'b0}}, 1'b1};
      end else if (r_drop_count != DROP_MAX) begin
        r_drop_count <= r_drop_count + 1'b1;
      end
    end else if (clear_overflow) begin
      r_overflow   <= 1'b0;
      r_drop_count <= '0;
    end
  end

  assign dout        = r_dout;
  assign dout_valid  = r_dout_valid;
  assign count       = r_count;
  assign almost_full = r_almost_full;
  assign overflow    = r_overflow;
  assign drop_count  = r_drop_count;

endmodule

// File: tb/tb_pipe_in_stream_fifo.sv
// Directed testbench for pipe_in_stream_fifo. Inputs are driven and outputs
// sampled 1 time unit after each rising edge.
module tb_pipe_in_stream_fifo;

  logic        ti_clk = 1'b0;
  logic        ti_reset;
  logic        ep_write;
  logic [31:0] ep_dataout;
  logic [31:0] dout;
  logic        dout_valid;
  logic        dout_ready;
  logic [4:0]  count;
  logic        almost_full;
  logic        overflow;
  logic [15:0] drop_count;
  logic        clear_overflow;

  int n_checks = 0;
  int n_errors = 0;

  pipe_in_stream_fifo #(
    .DEPTH(16), .ADDR_W(4), .AFULL_THRESH(12), .DROP_CNT_W(16)
  ) dut (
    .ti_clk(ti_clk),
    .ti_reset(ti_reset),
    .ep_write(ep_write),
    .ep_dataout(ep_dataout),
    .dout(dout),
    .dout_valid(dout_valid),
    .dout_ready(dout_ready),
    .count(count),
    .almost_full(almost_full),
    .overflow(overflow),
    .drop_count(drop_count),
    .clear_overflow(clear_overflow)
  );

  always #5 ti_clk = ~ti_clk;

  // Single comparison point for the whole bench.
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%08h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge ti_clk);
    #1;
  endtask

  task automatic do_reset();
    ti_reset = 1'b1;
    tick();
    ti_reset = 1'b0;
  endtask

  // Write n words base, base+1, ... with the consumer stalled.
  task automatic fill(input logic [31:0] base, input int n);
    dout_ready = 1'b0;
    for (int i = 0; i < n; i++) begin
      ep_write   = 1'b1;
      ep_dataout = base + 32'(i);
      tick();
    end
    ep_write = 1'b0;
  endtask

  // Expect the given word at the head, then pop it.
  task automatic expect_pop(input string tag, input logic [31:0] exp);
    dout_ready = 1'b1;
    check({tag, " valid"}, {31'd0, dout_valid}, 32'd1);
    check({tag, " dout"}, dout, exp);
    tick();
  endtask

  initial begin
    ti_reset = 1'b0; ep_write = 1'b0; ep_dataout = '0;
    dout_ready = 1'b0; clear_overflow = 1'b0;
    #1;
    do_reset();

    // Reset state.
    check("rst count", 32'(count), 32'd0);
    check("rst valid", {31'd0, dout_valid}, 32'd0);
    check("rst dout", dout, 32'd0);
    check("rst afull", {31'd0, almost_full}, 32'd0);
    check("rst overflow", {31'd0, overflow}, 32'd0);
    check("rst drops", 32'(drop_count), 32'd0);

    // 1: single word, one cycle of latency, popped immediately.
    dout_ready = 1'b1; ep_write = 1'b1; ep_dataout = 32'hDEADBEEF;
    tick();
    ep_write = 1'b0; ep_dataout = 32'h12345678;
    check("t1 no bypass valid", {31'd0, dout_valid}, 32'd0);
    check("t1 count1", 32'(count), 32'd1);
    tick();
    check("t1 valid", {31'd0, dout_valid}, 32'd1);
    check("t1 dout", dout, 32'hDEADBEEF);
    tick();
    check("t1 count0", 32'(count), 32'd0);
    check("t1 empty", {31'd0, dout_valid}, 32'd0);

    // 2: fill to full with the consumer stalled, then drain in order.
    dout_ready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      ep_write = 1'b1; ep_dataout = 32'(i);
      tick();
      check($sformatf("t2 count w%0d", i), 32'(count), 32'(i + 1));
      check($sformatf("t2 afull w%0d", i), {31'd0, almost_full}, (i + 1 >= 12) ? 32'd1 : 32'd0);
    end
    ep_write = 1'b0;
    check("t2 overflow", {31'd0, overflow}, 32'd0);
    check("t2 stall head", dout, 32'd0);
    tick();
    check("t2 stall hold", dout, 32'd0);
    check("t2 stall count", 32'(count), 32'd16);
    for (int i = 0; i < 16; i++) expect_pop($sformatf("t2 rd%0d", i), 32'(i));
    dout_ready = 1'b0;
    check("t2 drained", {31'd0, dout_valid}, 32'd0);
    check("t2 count0", 32'(count), 32'd0);

    // 3: writes into a full, stalled FIFO are dropped and counted.
    fill(32'd0, 16);
    ep_write = 1'b1; ep_dataout = 32'hAA; tick();
    ep_dataout = 32'hBB; tick();
    ep_write = 1'b0;
    check("t3 overflow", {31'd0, overflow}, 32'd1);
    check("t3 drops", 32'(drop_count), 32'd2);
    check("t3 count", 32'(count), 32'd16);
    for (int i = 0; i < 16; i++) expect_pop($sformatf("t3 rd%0d", i), 32'(i));
    dout_ready = 1'b0;
    check("t3 drained", {31'd0, dout_valid}, 32'd0);

    // 4: full FIFO, push coinciding with a pop is accepted.
    fill(32'd0, 16);
    tick();
    dout_ready = 1'b1; ep_write = 1'b1; ep_dataout = 32'h55;
    tick();
    ep_write = 1'b0;
    check("t4 count", 32'(count), 32'd16);
    check("t4 drops", 32'(drop_count), 32'd2);
    for (int i = 1; i < 16; i++) expect_pop($sformatf("t4 rd%0d", i), 32'(i));
    expect_pop("t4 last", 32'h55);
    dout_ready = 1'b0;
    check("t4 drained", {31'd0, dout_valid}, 32'd0);

    // 5: clear coinciding with a drop; drop wins. Then a clear alone.
    fill(32'd0, 16);
    ep_write = 1'b1; ep_dataout = 32'hCC; tick();
    ep_write = 1'b0;
    check("t5 drops3", 32'(drop_count), 32'd3);
    ep_write = 1'b1; ep_dataout = 32'hDD; clear_overflow = 1'b1; tick();
    ep_write = 1'b0;
    check("t5 clr+drop ovf", {31'd0, overflow}, 32'd1);
    check("t5 clr+drop cnt", 32'(drop_count), 32'd1);
    tick();
    clear_overflow = 1'b0;
    check("t5 clr ovf", {31'd0, overflow}, 32'd0);
    check("t5 clr cnt", 32'(drop_count), 32'd0);

    // 6: reset mid-burst flushes everything; fresh pointers afterwards.
    do_reset();
    fill(32'h100, 5);
    check("t6 count5", 32'(count), 32'd5);
    ep_write = 1'b1; ep_dataout = 32'h105; ti_reset = 1'b1;
    tick();
    ti_reset = 1'b0; ep_write = 1'b0;
    check("t6 count0", 32'(count), 32'd0);
    check("t6 valid0", {31'd0, dout_valid}, 32'd0);
    check("t6 dout0", dout, 32'd0);
    check("t6 afull0", {31'd0, almost_full}, 32'd0);
    dout_ready = 1'b1;
    tick(); tick();
    check("t6 quiet", {31'd0, dout_valid}, 32'd0);
    fill(32'h200, 3);
    tick();
    for (int i = 0; i < 3; i++) expect_pop($sformatf("t6 rd%0d", i), 32'h200 + 32'(i));
    check("t6 drained", {31'd0, dout_valid}, 32'd0);
    check("t6 count end", 32'(count), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
